fetch_unit: RTL

Instruction-fetch stage of the single-issue CPU: owns the program counter, drives the instruction memory read address, and captures the returned instruction into the IF/ID pipeline register for decode. It handles sequential fetch, branch/jump redirects, decode-stage stalls, and halts cleanly when the PC leaves the loaded program image. The instruction memory stays a separate combinational block instantiated beside this unit at CPU top level.

---
 rtl/cpu_pkg.sv | 27 ++
 rtl/fetch_unit_if.sv | 27 ++
 rtl/if_id_reg.sv | 22 ++
 rtl/fetch_unit.sv | 85 ++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants and types for fetch, decode and execute stages.
// Pure declarations: no latency or backpressure of its own.
package cpu_pkg;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] INSTR_BYTES      = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '{instr: NOP_INSTR, pc4: 32'h0, valid: 1'b0};

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    // Word-aligned and inside the loaded image.
    function automatic logic pc_legal(input logic [31:0] pc, input int unsigned depth_words);
        return (pc[1:0] == 2'b00) && (pc[31:2] < 30'(depth_words));
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: PC/instruction memory pair, redirect and stall controls, IF/ID outputs.
// master = fetch_unit, slave = surrounding core (imem, decode, execute).
interface fetch_unit_if;

    logic [31:0] pc_out;
    logic [31:0] instr_in;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic        fetch_fault;

    modport master (
        output pc_out, if_id_instr, if_id_pc4, if_id_valid, fetch_fault,
        input  instr_in, stall, branch_taken, branch_target, jump, jump_target
    );

    modport slave (
        input  pc_out, if_id_instr, if_id_pc4, if_id_valid, fetch_fault,
        output instr_in, stall, branch_taken, branch_target, jump, jump_target
    );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: one-cycle load, bubble insert, or hold.
// Hold is the stall path; reset and bubble both clear to a NOP with valid low.
module if_id_reg
    import cpu_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   load,
    input  logic   bubble,
    input  if_id_t d,
    output if_id_t q
);

    always_ff @(posedge clk) begin
        if (reset || bubble) begin
            q <= IF_ID_BUBBLE;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, next-PC select, legality check, RUN/HALT FSM.
// One instr/cycle, one-cycle fetch latency, one bubble per redirect; stall holds all state.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter int unsigned DEPTH_WORDS = 21
) (
    input  logic           clk,
    input  logic           reset,
    fetch_unit_if.master   bus
);

    fetch_state_t state;
    logic [31:0]  pc_q;
    logic         fault_q;
    logic         legal;
    logic         ifid_load;
    logic         ifid_bubble;
    if_id_t       ifid_d;
    if_id_t       ifid_q;

    assign legal  = pc_legal(pc_q, DEPTH_WORDS);
    assign ifid_d = '{instr: bus.instr_in, pc4: pc_q + INSTR_BYTES, valid: 1'b1};

    // IF/ID control mirrors the PC priority below so both update on the same edge.
    always_comb begin
        ifid_load   = 1'b0;
        ifid_bubble = 1'b0;
        if (state == HALT) begin
            ifid_bubble = 1'b1;
        end else if (bus.branch_taken || bus.jump) begin
            ifid_bubble = 1'b1;
        end else if (!bus.stall) begin
            ifid_load   = legal;
            ifid_bubble = !legal;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= RUN;
            pc_q    <= RESET_PC;
            fault_q <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (bus.branch_taken) begin
                        pc_q <= bus.branch_target;
                    end else if (bus.jump) begin
                        pc_q <= bus.jump_target;
                    end else if (!bus.stall) begin
                        if (legal) begin
                            pc_q <= pc_q + INSTR_BYTES;
                        end else begin
                            // PC stays on the offending address for debug visibility.
                            fault_q <= 1'b1;
                            state   <= HALT;
                        end
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: state <= HALT;
            endcase
        end
    end

    if_id_reg u_if_id_reg (
        .clk    (clk),
        .reset  (reset),
        .load   (ifid_load),
        .bubble (ifid_bubble),
        .d      (ifid_d),
        .q      (ifid_q)
    );

    assign bus.pc_out      = pc_q;
    assign bus.if_id_instr = ifid_q.instr;
    assign bus.if_id_pc4   = ifid_q.pc4;
    assign bus.if_id_valid = ifid_q.valid;
    assign bus.fetch_fault = fault_q;

endmodule
